// File: rtl/univ_ff_pkg.sv
// Shared types and constants for the universal flip-flop register bank.
// Mode encodings match the legacy lab boards: SR, JK, D, T.
package univ_ff_pkg;

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_t;

    // Next-state of one bit for the given mode; SR 11 holds (flagged elsewhere).
    function automatic logic next_bit(input mode_t mode, input logic q,
                                      input logic a, input logic b);
        logic nq;
        nq = q;
        unique case (mode)
            MODE_SR: begin
                if (a && !b)      nq = 1'b1;
                else if (!a && b) nq = 1'b0;
            end
            MODE_JK: begin
                if (a && b)       nq = ~q;
                else if (a)       nq = 1'b1;
                else if (b)       nq = 1'b0;
            end
            MODE_D:               nq = a;
            MODE_T:               nq = q ^ a;
            default:              nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/univ_ff_reg_if.sv
// Control/data bundle between a driver and the univ_ff_reg register bank.
// The master drives mode and operands; the slave (the bank) returns state and error status.
interface univ_ff_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    import univ_ff_pkg::*;

    logic             en;
    mode_t            mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clr_err;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output en, mode, a, b, clr_err,
        input  q, qbar, err, err_cnt
    );

    modport slave (
        input  en, mode, a, b, clr_err,
        output q, qbar, err, err_cnt
    );

endinterface

// File: rtl/univ_ff_cell.sv
// One storage bit of the universal register: SR/JK/D/T behaviour chosen by mode.
// Reports the SR 11 combination as illegal; that bit then holds.
module univ_ff_cell
    import univ_ff_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  mode_t mode,
    input  logic  a,
    input  logic  b,
    input  logic  rst_val,
    output logic  q,
    output logic  illegal
);

    logic q_next;

    assign q_next  = next_bit(mode, q, a, b);
    assign illegal = en && (mode == MODE_SR) && a && b;

    // NOTE: state registers use non-blocking assignments so every bit samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= rst_val;
        end else if (en) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/univ_ff_reg.sv
// WIDTH-bit multi-mode register bank with a sticky SR-illegal flag and a saturating error counter.
// Bits are independent cells; this level only combines their illegal outputs.
module univ_ff_reg
    import univ_ff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    univ_ff_reg_if.slave  bus
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] ill_bits;
    logic             illegal;
    logic             err_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        univ_ff_cell u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (bus.en),
            .mode    (bus.mode),
            .a       (bus.a[i]),
            .b       (bus.b[i]),
            .rst_val (RESET_VAL[i]),
            .q       (q_r[i]),
            .illegal (ill_bits[i])
        );
    end

    // Several offending bits in one cycle still count as a single event.
    assign illegal = |ill_bits;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        cnt_next = cnt_r;
        if (bus.clr_err) begin
            cnt_next = illegal ? CNT_W'(1) : '0;
        end else if (illegal && !(&cnt_r)) begin
            cnt_next = cnt_r + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_next;
            if (bus.clr_err) begin
                err_r <= illegal;
            end else if (illegal) begin
                err_r <= 1'b1;
            end
        end
    end

    assign bus.q       = q_r;
    assign bus.qbar    = ~q_r;
    assign bus.err     = err_r;
    assign bus.err_cnt = cnt_r;

endmodule

// File: tb/tb_univ_ff_reg.sv
// Directed bench for univ_ff_reg at WIDTH=4, RESET_VAL=4'b1010, CNT_W=2.
// Each scenario task compares {q, qbar, err, err_cnt} against hand-computed values.
module tb_univ_ff_reg;
    import univ_ff_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    univ_ff_reg_if #(.WIDTH(4), .CNT_W(2)) bus ();

    univ_ff_reg #(
        .WIDTH     (4),
        .RESET_VAL (4'b1010),
        .CNT_W     (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] snap();
        return {bus.q, bus.qbar, bus.err, bus.err_cnt};
    endfunction

    // Drive one vector at the falling edge, then let one rising edge pass.
    task automatic step(input logic en, input mode_t mode, input logic [3:0] a,
                        input logic [3:0] b, input logic clr);
        @(negedge clk);
        bus.en      = en;
        bus.mode    = mode;
        bus.a       = a;
        bus.b       = b;
        bus.clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] got;
        rst_n       = 1'b0;
        bus.en      = 1'b1;
        bus.mode    = MODE_D;
        bus.a       = 4'b1111;
        bus.b       = 4'b0000;
        bus.clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got = snap();
        n_cmp++;
        if (got !== {4'b1010, 4'b0101, 1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL reset_hold: got=%b expected=%b", got, {4'b1010, 4'b0101, 1'b0, 2'd0});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_async_reset();
        logic [10:0] got;
        step(1'b1, MODE_D, 4'b0110, 4'b0000, 1'b0);
        step(1'b1, MODE_SR, 4'b0001, 4'b0001, 1'b0);
        got = snap();
        n_cmp++;
        if (got !== {4'b0110, 4'b1001, 1'b1, 2'd1}) begin
            n_bad++;
            $display("FAIL async_setup: got=%b expected=%b", got, {4'b0110, 4'b1001, 1'b1, 2'd1});
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = snap();
        n_cmp++;
        if (got !== {4'b1010, 4'b0101, 1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL async_reset_midcycle: got=%b expected=%b", got, {4'b1010, 4'b0101, 1'b0, 2'd0});
        end
        step(1'b1, MODE_D, 4'b1111, 4'b0000, 1'b0);
        got = snap();
        n_cmp++;
        if (got !== {4'b1010, 4'b0101, 1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL async_reset_held_edge: got=%b expected=%b", got, {4'b1010, 4'b0101, 1'b0, 2'd0});
        end
        @(negedge clk);
        bus.en = 1'b0;
        rst_n  = 1'b1;
    endtask

    task automatic test_sr();
        logic [3:0]  va [3];
        logic [3:0]  vb [3];
        logic [10:0] ve [3];
        logic [10:0] got;
        va = '{4'b0000, 4'b0101, 4'b0011};
        vb = '{4'b1111, 4'b0000, 4'b0110};
        ve = '{{4'b0000, 4'b1111, 1'b0, 2'd0},
               {4'b0101, 4'b1010, 1'b0, 2'd0},
               {4'b0001, 4'b1110, 1'b1, 2'd1}};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, MODE_SR, va[i], vb[i], 1'b0);
            got = snap();
            n_cmp++;
            if (got !== ve[i]) begin
                n_bad++;
                $display("FAIL sr_vec%0d: got=%b expected=%b", i, got, ve[i]);
            end
        end
    endtask

    task automatic test_jk_t();
        mode_t       vm [4];
        logic [3:0]  va [4];
        logic [3:0]  vb [4];
        logic [10:0] ve [4];
        logic [10:0] got;
        vm = '{MODE_JK, MODE_JK, MODE_T, MODE_JK};
        va = '{4'b1111, 4'b1111, 4'b1000, 4'b0100};
        vb = '{4'b1111, 4'b1111, 4'b0000, 4'b0001};
        ve = '{{4'b1110, 4'b0001, 1'b1, 2'd1},
               {4'b0001, 4'b1110, 1'b1, 2'd1},
               {4'b1001, 4'b0110, 1'b1, 2'd1},
               {4'b1100, 4'b0011, 1'b1, 2'd1}};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vm[i], va[i], vb[i], 1'b0);
            got = snap();
            n_cmp++;
            if (got !== ve[i]) begin
                n_bad++;
                $display("FAIL jk_t_vec%0d: got=%b expected=%b", i, got, ve[i]);
            end
        end
    endtask

    task automatic test_d_enable();
        logic [10:0] got;
        step(1'b1, MODE_D, 4'b0111, 4'b1111, 1'b0);
        got = snap();
        n_cmp++;
        if (got !== {4'b0111, 4'b1000, 1'b1, 2'd1}) begin
            n_bad++;
            $display("FAIL d_load: got=%b expected=%b", got, {4'b0111, 4'b1000, 1'b1, 2'd1});
        end
        step(1'b0, MODE_D, 4'b1111, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, MODE_SR, 4'b1111, 4'b1111, 1'b0);
        end
        got = snap();
        n_cmp++;
        if (got !== {4'b0111, 4'b1000, 1'b1, 2'd1}) begin
            n_bad++;
            $display("FAIL en_low_hold: got=%b expected=%b", got, {4'b0111, 4'b1000, 1'b1, 2'd1});
        end
    endtask

    task automatic test_saturation_clear();
        logic [1:0]  exp_cnt;
        logic [10:0] got;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, MODE_SR, 4'b1111, 4'b1111, 1'b0);
            exp_cnt = (i == 0) ? 2'd2 : 2'd3;
            got = snap();
            n_cmp++;
            if (got !== {4'b0111, 4'b1000, 1'b1, exp_cnt}) begin
                n_bad++;
                $display("FAIL saturate_%0d: got=%b expected=%b", i, got, {4'b0111, 4'b1000, 1'b1, exp_cnt});
            end
        end
        step(1'b1, MODE_D, 4'b0000, 4'b0000, 1'b1);
        got = snap();
        n_cmp++;
        if (got !== {4'b0000, 4'b1111, 1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL clear_legal: got=%b expected=%b", got, {4'b0000, 4'b1111, 1'b0, 2'd0});
        end
        step(1'b1, MODE_SR, 4'b0011, 4'b0001, 1'b1);
        got = snap();
        n_cmp++;
        if (got !== {4'b0010, 4'b1101, 1'b1, 2'd1}) begin
            n_bad++;
            $display("FAIL clear_with_illegal: got=%b expected=%b", got, {4'b0010, 4'b1101, 1'b1, 2'd1});
        end
        step(1'b0, MODE_SR, 4'b1111, 4'b1111, 1'b1);
        got = snap();
        n_cmp++;
        if (got !== {4'b0010, 4'b1101, 1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL clear_en_low: got=%b expected=%b", got, {4'b0010, 4'b1101, 1'b0, 2'd0});
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_async_reset();
        test_sr();
        test_jk_t();
        test_d_enable();
        test_saturation_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/univ_ff_reg.md
# univ_ff_reg

- Parametrised, multi-mode register bank for the flip-flop lab series: WIDTH independent storage bits.
- All bits share one mode select; MODE chooses SR, JK, D or T behaviour for every bit at once.
- Detects the forbidden SR input combination. Keeps a sticky error flag and a saturating count of the cycles in which it occurred.
- Sits where single SR/JK/D/T flip-flops were used before. Acts as a reusable state-holding element for counters and FSM exercises.

## Interface
Parameters:
- WIDTH, 8, number of storage bits (≥1)
- RESET_VAL, all zeros, WIDTH-bit value loaded into Q on reset
- CNT_W, 8, width of the error counter (≥2)

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RST_N  input  1  reset, asynchronous, active-low
- EN  input  1  update enable; when low, Q, ERR and ERR_CNT hold
- MODE  input  2  00 SR, 01 JK, 10 D, 11 T
- A  input  WIDTH  per-bit first operand: S / J / D / T
- B  input  WIDTH  per-bit second operand: R / K; ignored in D and T modes
- CLR_ERR  input  1  synchronous clear of ERR and ERR_CNT
- Q  output  WIDTH  registered state
- Qbar  output  WIDTH  combinational ~Q
- ERR  output  1  sticky flag: at least one SR-illegal bit seen since the last clear
- ERR_CNT  output  CNT_W  count of cycles with at least one illegal bit; saturates at all-ones

## Operation
Per-bit next state, evaluated only when EN=1:
- SR (00), A=S, B=R: 00 hold, 01 →0, 10 →1.
  - 11 is illegal. That bit holds, and the illegal condition is raised for the cycle.
- JK (01), A=J, B=K: 00 hold, 01 →0, 10 →1, 11 toggle. Never illegal.
- D (10): Q[i] ← A[i].
- T (11): A[i]=1 toggles, A[i]=0 holds.

Error logic:
- illegal = EN & (MODE==SR) & |(A & B).
- Counter update, in priority order:
  1. CLR_ERR=1 and illegal → ERR=1, ERR_CNT=1.
  2. CLR_ERR=1 alone → ERR=0, ERR_CNT=0.
  3. illegal alone → ERR=1; ERR_CNT increments unless already all-ones (no wrap).
- CLR_ERR is honoured even when EN=0. With EN=0, illegal is 0.
- Legal bits in an illegal cycle still update normally. Only the offending bits hold.

Mode changes:
- A MODE change takes effect on the same edge. No state is carried between modes beyond Q itself.

## Timing
Reset:
- RST_N low asynchronously forces Q=RESET_VAL, Qbar=~RESET_VAL, ERR=0, ERR_CNT=0 without waiting for CLK.
- This holds even in the middle of an operation; there is no partial update.
- Deassertion is sampled synchronously. The first update happens on the first rising edge with RST_N=1.

Latency:
- Q, ERR and ERR_CNT change one rising edge after their inputs are sampled.
- Inputs must be stable across the sampling edge. There is no combinational path from inputs to outputs.
- Qbar follows Q combinationally, with zero cycles of added latency.

Boundary conditions:
- EN=0 with MODE/A/B changing: all state holds.
- ERR_CNT at all-ones with a further illegal cycle: stays at all-ones, ERR stays 1.
- Several illegal bits in one cycle count once.
- Toggle in JK 11 or T mode inverts every selected bit on each enabled edge.

## Structure
- Package univ_ff_pkg: MODE encodings MODE_SR, MODE_JK, MODE_D, MODE_T, plus the 2-bit mode type.
- Sub-module univ_ff_cell:
  - One bit: CLK, RST_N, EN, MODE, a, b, reset value in; q and illegal out.
  - Instantiated WIDTH times with a generate loop.
- The top level holds the OR-reduction of the per-bit illegal signals and the ERR/ERR_CNT logic.

## Test plan
Run with WIDTH=4, RESET_VAL=4'b1010, CNT_W=2.

1. Async reset: mid-cycle RST_N 1→0 with Q=4'b0110 → Q=4'b1010 and Qbar=4'b0101 immediately, before the next edge. ERR=0, ERR_CNT=0.
2. SR sequence, MODE=00, EN=1:
   - A=0000, B=1111 → Q=0000.
   - A=0101, B=0000 → Q=0101.
   - A=0011, B=0110 → bit1 illegal and holds 0; bit0 set; bit2 reset. Result Q=0001, ERR=1, ERR_CNT=1.
3. JK/T toggling:
   - MODE=01, A=B=1111 from Q=0001 → Q=1110, then Q=0001 on the next edge.
   - MODE=11, A=1000 → Q=1001.
4. D and enable:
   - MODE=10, A=0111 → Q=0111.
   - EN=0 with A=1111 and MODE=00, A=B=1111 for 3 edges → Q=0111 unchanged, ERR_CNT unchanged.
5. Saturation and clear:
   - 5 consecutive illegal SR cycles → ERR_CNT=3 (saturated), ERR=1.
   - CLR_ERR=1 with a legal input → ERR=0, ERR_CNT=0.
   - CLR_ERR=1 together with an illegal input → ERR=1, ERR_CNT=1.
